stack_ctrl: RTL

STACK_CTRL -- requirements
Module: stack_ctrl

---
 rtl/stack_ctrl_pkg.sv | 9 +
 rtl/stack_occupancy.sv | 22 ++
 rtl/stack_ctrl.sv | 80 ++++++++
 3 files changed

// File: rtl/stack_ctrl_pkg.sv
// stack_ctrl_pkg: shared op/state encodings, default depth and bus widths
package stack_ctrl_pkg;
  localparam int DEPTH_DEF = 5;
  localparam int DW = 4;
  localparam int IW = 3;
  localparam int CW = 3;
  typedef enum logic [1:0] {OP_NOP, OP_PUSH, OP_POP, OP_GET} op_e;
  typedef enum logic [1:0] {IDLE, STROBE, RESP} state_e;
endpackage

// File: rtl/stack_occupancy.sv
// stack_occupancy: saturating occupancy counter with full/empty flags
module stack_occupancy
  import stack_ctrl_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  always_ff @(posedge clk) begin
    if (clr) count <= '0;
    else if (inc && !full) count <= count + 1'b1;
    else if (dec && !empty) count <= count - 1'b1;
  end
endmodule

// File: rtl/stack_ctrl.sv
// stack_ctrl: request/response front end sequencing a downstream stack
module stack_ctrl
  import stack_ctrl_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_op,
  input  logic [DW-1:0] req_data,
  input  logic [IW-1:0] req_index,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_err,
  output logic [CW-1:0] count,
  output logic [1:0]    stk_command,
  output logic [IW-1:0] stk_index,
  output logic          stk_clk,
  output logic          stk_reset,
  output logic [DW-1:0] stk_data_out,
  output logic          stk_data_oe,
  input  logic [DW-1:0] stk_data_in
);
  state_e state, state_d;
  op_e op_q;
  logic [DW-1:0] data_q;
  logic [IW-1:0] index_q;
  logic full, empty, accept, err, go;
  assign req_ready = state == IDLE && !stk_reset;
  assign accept = req_valid && req_ready;
  assign err = (req_op == OP_PUSH && full) || ((req_op == OP_POP || req_op == OP_GET) && empty) ||
               (req_op == OP_GET && req_index >= count);
  assign go = req_op != OP_NOP && !err;
  assign rsp_valid = state == RESP;
  assign stk_clk = state == STROBE;
  assign stk_command = stk_clk ? op_q : OP_NOP;
  assign stk_index = stk_clk && op_q == OP_GET ? index_q : '0;
  assign stk_data_oe = stk_clk && op_q == OP_PUSH;
  assign stk_data_out = stk_data_oe ? data_q : '0;
  always_comb begin
    state_d = state;
    if (state == IDLE && accept) state_d = go ? STROBE : RESP;
    else if (state == STROBE) state_d = RESP;
    else if (state == RESP && rsp_ready) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  end
  always_ff @(posedge clk) begin
    stk_reset <= !rst_n;
    if (!rst_n) begin
      op_q <= OP_NOP;
      data_q <= '0;
      index_q <= '0;
      rsp_data <= '0;
      rsp_err <= 1'b0;
    end else if (accept) begin
      op_q <= op_e'(req_op);
      data_q <= req_data;
      index_q <= req_index;
      rsp_data <= '0;
      rsp_err <= err;
    end else if (stk_clk && op_q != OP_PUSH) begin
      rsp_data <= stk_data_in;
    end
  end
  stack_occupancy #(.DEPTH(DEPTH)) u_occ (
    .clk  (clk),
    .clr  (!rst_n),
    .inc  (stk_clk && op_q == OP_PUSH),
    .dec  (stk_clk && op_q == OP_POP),
    .count(count),
    .full (full),
    .empty(empty)
  );
endmodule
